// File: rtl/axil_pkg.sv
// Shared types and constants for the AXI4-Lite write slave and its register file.
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GOT_AW = 2'd1,
        ST_GOT_W  = 2'd2,
        ST_RESP   = 2'd3
    } wr_state_e;

    // Ceiling log2, usable in constant expressions for port widths.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/axil_regfile_be.sv
// NUM_REGS x DATA_W register file: byte-enabled synchronous write, asynchronous read.
module axil_regfile_be
    import axil_pkg::*;
#(
    parameter int unsigned          DATA_W   = 32,
    parameter int unsigned          NUM_REGS = 128,
    parameter logic [DATA_W-1:0]    RST_VAL  = '0,
    localparam int unsigned         IDX_W    = clog2(NUM_REGS),
    localparam int unsigned         STRB_W   = DATA_W / 8
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic                we,
    input  logic [IDX_W-1:0]    widx,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [STRB_W-1:0]   wstrb,
    input  logic [IDX_W-1:0]    ridx,
    output logic [DATA_W-1:0]   rdata
);

    logic [DATA_W-1:0] mem [NUM_REGS];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                mem[i] <= RST_VAL;
            end
        end else if (we) begin
            for (int unsigned b = 0; b < STRB_W; b++) begin
                if (wstrb[b]) mem[widx][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    assign rdata = mem[ridx];

endmodule

// File: rtl/axil_write_slave_strb.sv
// AXI4-Lite write-channel slave: AW/W in any order, byte strobes, SLVERR on
// out-of-range addresses, plus a read port and a commit strobe for observers.
module axil_write_slave_strb
    import axil_pkg::*;
#(
    parameter int unsigned          DATA_W   = 32,
    parameter int unsigned          ADDR_W   = 32,
    parameter int unsigned          NUM_REGS = 128,
    parameter logic [DATA_W-1:0]    RST_VAL  = '0,
    localparam int unsigned         IDX_W    = clog2(NUM_REGS),
    localparam int unsigned         STRB_W   = DATA_W / 8
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic                awvalid,
    input  logic [ADDR_W-1:0]   awaddr,
    output logic                awready,
    input  logic                wvalid,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [STRB_W-1:0]   wstrb,
    output logic                wready,
    output logic                bvalid,
    output logic [1:0]          bresp,
    input  logic                bready,
    input  logic [IDX_W-1:0]    rd_idx,
    output logic [DATA_W-1:0]   rd_data,
    output logic                wr_pulse,
    output logic [IDX_W-1:0]    wr_idx
);

    localparam int unsigned LSB = clog2(STRB_W);

    wr_state_e              state;
    logic [ADDR_W-1:0]      aw_addr_q;
    logic [DATA_W-1:0]      w_data_q;
    logic [STRB_W-1:0]      w_strb_q;

    logic                   aw_hs;
    logic                   w_hs;
    logic                   commit;
    logic [ADDR_W-1:0]      c_addr;
    logic [DATA_W-1:0]      c_data;
    logic [STRB_W-1:0]      c_strb;
    logic [IDX_W-1:0]       c_idx;
    logic                   c_in_range;
    logic                   reg_we;

    // The half that arrived first comes from its latch; the other straight off the bus.
    always_comb begin
        aw_hs      = awvalid && awready;
        w_hs       = wvalid && wready;
        c_addr     = (state == ST_GOT_AW) ? aw_addr_q : awaddr;
        c_data     = (state == ST_GOT_W)  ? w_data_q  : wdata;
        c_strb     = (state == ST_GOT_W)  ? w_strb_q  : wstrb;
        commit     = 1'b0;
        case (state)
            ST_IDLE:   commit = aw_hs && w_hs;
            ST_GOT_AW: commit = w_hs;
            ST_GOT_W:  commit = aw_hs;
            default:   commit = 1'b0;
        endcase
        c_idx      = c_addr[LSB +: IDX_W];
        c_in_range = (c_addr >> (LSB + IDX_W)) == '0;
        reg_we     = commit && c_in_range && (c_strb != '0);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state     <= ST_IDLE;
            awready   <= 1'b1;
            wready    <= 1'b1;
            bvalid    <= 1'b0;
            bresp     <= RESP_OKAY;
            wr_pulse  <= 1'b0;
            wr_idx    <= '0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
        end else begin
            wr_pulse <= 1'b0;
            if (commit) begin
                state    <= ST_RESP;
                awready  <= 1'b0;
                wready   <= 1'b0;
                bvalid   <= 1'b1;
                bresp    <= c_in_range ? RESP_OKAY : RESP_SLVERR;
                wr_pulse <= reg_we;
                if (reg_we) wr_idx <= c_idx;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (aw_hs) begin
                            state     <= ST_GOT_AW;
                            awready   <= 1'b0;
                            aw_addr_q <= awaddr;
                        end else if (w_hs) begin
                            state    <= ST_GOT_W;
                            wready   <= 1'b0;
                            w_data_q <= wdata;
                            w_strb_q <= wstrb;
                        end
                    end
                    ST_RESP: begin
                        if (bready) begin
                            state   <= ST_IDLE;
                            bvalid  <= 1'b0;
                            awready <= 1'b1;
                            wready  <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    axil_regfile_be #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .RST_VAL  (RST_VAL)
    ) u_regs (
        .aclk    (aclk),
        .aresetn (aresetn),
        .we      (reg_we),
        .widx    (c_idx),
        .wdata   (c_data),
        .wstrb   (c_strb),
        .ridx    (rd_idx),
        .rdata   (rd_data)
    );

endmodule

// File: tb/tb_axil_write_slave_strb.sv
// Bench for axil_write_slave_strb: vector table, hand-written corner sequences, random traffic vs a register-array model.
module tb_axil_write_slave_strb;

    logic        aclk;
    logic        aresetn;
    logic        awvalid;
    logic [31:0] awaddr;
    logic        awready;
    logic        wvalid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wready;
    logic        bvalid;
    logic [1:0]  bresp;
    logic        bready;
    logic [6:0]  rd_idx;
    logic [31:0] rd_data;
    logic        wr_pulse;
    logic [6:0]  wr_idx;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] model [128];

    axil_write_slave_strb #(
        .DATA_W   (32),
        .ADDR_W   (32),
        .NUM_REGS (128),
        .RST_VAL  (32'h0)
    ) dut (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .awvalid  (awvalid),
        .awaddr   (awaddr),
        .awready  (awready),
        .wvalid   (wvalid),
        .wdata    (wdata),
        .wstrb    (wstrb),
        .wready   (wready),
        .bvalid   (bvalid),
        .bresp    (bresp),
        .bready   (bready),
        .rd_idx   (rd_idx),
        .rd_data  (rd_data),
        .wr_pulse (wr_pulse),
        .wr_idx   (wr_idx)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got hang expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: an in-range write updates only the enabled byte lanes.
    function automatic void model_write(input logic [31:0] addr, input logic [31:0] data,
                                        input logic [3:0] strb);
        int unsigned idx;
        if ((addr / 512) != 0) return;
        idx = (addr / 4) % 128;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) model[idx][b*8 +: 8] = data[b*8 +: 8];
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 128; i++) model[i] = 32'h0;
    endfunction

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_dly, input int w_dly, input int b_dly,
                             output logic [1:0] resp, output int pulses,
                             output logic [6:0] pidx, output bit ok);
        bit aw_done, w_done, b_done, aw_fire, w_fire, b_fire;
        int bw;
        aw_done = 0; w_done = 0; b_done = 0; bw = 0;
        resp = 2'bxx; pulses = 0; pidx = '0;
        awaddr = addr; wdata = data; wstrb = strb;
        for (int c = 0; c < 60 && !b_done; c++) begin
            @(negedge aclk);
            if (wr_pulse) begin
                pulses++;
                pidx = wr_idx;
            end
            awvalid = !aw_done && (c >= aw_dly);
            wvalid  = !w_done && (c >= w_dly);
            aw_fire = awvalid && awready;
            w_fire  = wvalid && wready;
            b_fire  = 0;
            bready  = 1'b0;
            if (bvalid) begin
                if (bw >= b_dly) begin
                    bready = 1'b1;
                    b_fire = 1;
                    resp   = bresp;
                end else begin
                    bw++;
                end
            end
            @(posedge aclk);
            if (aw_fire) aw_done = 1;
            if (w_fire)  w_done = 1;
            if (b_fire)  b_done = 1;
        end
        @(negedge aclk);
        if (wr_pulse) pulses++;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        bready  = 1'b0;
        ok = b_done;
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          aw_dly;
        int          w_dly;
        logic [1:0]  exp_resp;
        int          exp_pulses;
        logic [6:0]  exp_idx;
        logic [6:0]  rd;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [8];

    logic [1:0]  resp;
    int          pulses;
    logic [6:0]  pidx;
    bit          ok;

    initial begin
        vecs[0] = '{32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, 2'b00, 1, 7'd4,   7'd4,   32'hDEAD_BEEF};
        vecs[1] = '{32'h0000_0008, 32'h1234_5678, 4'hF, 3, 0, 2'b00, 1, 7'd2,   7'd2,   32'h1234_5678};
        vecs[2] = '{32'h0000_0004, 32'hAABB_CCDD, 4'hF, 0, 0, 2'b00, 1, 7'd1,   7'd1,   32'hAABB_CCDD};
        vecs[3] = '{32'h0000_0004, 32'h1122_3344, 4'h5, 1, 1, 2'b00, 1, 7'd1,   7'd1,   32'hAA22_CC44};
        vecs[4] = '{32'h0000_0200, 32'hFFFF_FFFF, 4'hF, 0, 0, 2'b10, 0, 7'd0,   7'd0,   32'h0000_0000};
        vecs[5] = '{32'h0000_01FF, 32'hCAFE_F00D, 4'hF, 0, 2, 2'b00, 1, 7'd127, 7'd127, 32'hCAFE_F00D};
        vecs[6] = '{32'h0000_0012, 32'h0000_0000, 4'h0, 0, 0, 2'b00, 0, 7'd0,   7'd4,   32'hDEAD_BEEF};
        vecs[7] = '{32'h8000_0010, 32'h0000_0000, 4'hF, 2, 0, 2'b10, 0, 7'd0,   7'd4,   32'hDEAD_BEEF};

        aresetn = 1'b0; awvalid = 1'b0; awaddr = '0; wvalid = 1'b0; wdata = '0;
        wstrb = '0; bready = 1'b0; rd_idx = '0;
        model_reset();
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("rst_awready", awready, 1);
        chk("rst_wready", wready, 1);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_bresp", bresp, 0);
        chk("rst_wr_pulse", wr_pulse, 0);
        chk("rst_wr_idx", wr_idx, 0);
        rd_idx = 7'd5;
        #1 chk("rst_reg5", rd_data, 0);
        aresetn = 1'b1;

        for (int i = 0; i < 8; i++) begin
            model_write(vecs[i].addr, vecs[i].data, vecs[i].strb);
            axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].aw_dly, vecs[i].w_dly, 0,
                      resp, pulses, pidx, ok);
            chk($sformatf("vec%0d_done", i), ok, 1);
            chk($sformatf("vec%0d_bresp", i), resp, vecs[i].exp_resp);
            chk($sformatf("vec%0d_pulses", i), pulses, vecs[i].exp_pulses);
            if (vecs[i].exp_pulses != 0) chk($sformatf("vec%0d_wr_idx", i), pidx, vecs[i].exp_idx);
            rd_idx = vecs[i].rd;
            #1 chk($sformatf("vec%0d_rd", i), rd_data, vecs[i].exp_rd);
            if (vecs[i].exp_resp == 2'b10) begin
                int bad;
                bad = 0;
                for (int r = 0; r < 128; r++) begin
                    rd_idx = 7'(r);
                    #1 if (rd_data !== model[r]) bad++;
                end
                chk($sformatf("vec%0d_regs_unchanged", i), bad, 0);
            end
        end

        // W arrives first; slave must hold wready low until AW completes it.
        @(negedge aclk);
        wdata = 32'h0BAD_F00D; wstrb = 4'hF; wvalid = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        wvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("wfirst_wready_low", wready, 0);
            chk("wfirst_awready_high", awready, 1);
            chk("wfirst_no_bvalid", bvalid, 0);
            @(negedge aclk);
        end
        awaddr = 32'h0000_000C; awvalid = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        awvalid = 1'b0;
        chk("wfirst_bvalid", bvalid, 1);
        chk("wfirst_bresp", bresp, 0);
        chk("wfirst_pulse", wr_pulse, 1);
        chk("wfirst_wr_idx", wr_idx, 3);
        bready = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        bready = 1'b0;
        chk("wfirst_pulse_one_cycle", wr_pulse, 0);
        model_write(32'h0000_000C, 32'h0BAD_F00D, 4'hF);
        rd_idx = 7'd3;
        #1 chk("wfirst_reg3", rd_data, model[3]);

        // Backpressure on B.
        @(negedge aclk);
        awaddr = 32'h0000_0030; wdata = 32'h55AA_55AA; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        awvalid = 1'b0; wvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_bvalid", bvalid, 1);
            chk("bp_bresp", bresp, 0);
            chk("bp_awready", awready, 0);
            chk("bp_wready", wready, 0);
            @(negedge aclk);
        end
        bready = 1'b1;
        @(posedge aclk);
        #1;
        chk("bp_awready_rise", awready, 1);
        chk("bp_wready_rise", wready, 1);
        chk("bp_bvalid_fall", bvalid, 0);
        @(negedge aclk);
        bready = 1'b0;
        model_write(32'h0000_0030, 32'h55AA_55AA, 4'hF);
        rd_idx = 7'd12;
        #1 chk("bp_reg12", rd_data, model[12]);

        // Reset while an address is latched.
        @(negedge aclk);
        awaddr = 32'h0000_0020; awvalid = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        awvalid = 1'b0;
        chk("abort_in_got_aw", awready, 0);
        aresetn = 1'b0;
        model_reset();
        #1;
        chk("abort_awready", awready, 1);
        chk("abort_wready", wready, 1);
        chk("abort_bvalid", bvalid, 0);
        rd_idx = 7'd4;
        #1 chk("abort_reg4_cleared", rd_data, 0);
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        wdata = 32'h7777_7777; wstrb = 4'hF; wvalid = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        wvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("abort_no_bvalid", bvalid, 0);
            chk("abort_no_pulse", wr_pulse, 0);
            @(negedge aclk);
        end
        chk("abort_waiting_aw", awready, 1);
        awaddr = 32'h0000_0024; awvalid = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        awvalid = 1'b0;
        chk("abort_resume_bvalid", bvalid, 1);
        chk("abort_resume_idx", wr_idx, 9);
        bready = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        bready = 1'b0;
        model_write(32'h0000_0024, 32'h7777_7777, 4'hF);
        rd_idx = 7'd8;
        #1 chk("abort_reg8_untouched", rd_data, model[8]);
        rd_idx = 7'd9;
        #1 chk("abort_reg9", rd_data, model[9]);

        // Random traffic.
        for (int t = 0; t < 80; t++) begin
            logic [31:0] addr, data;
            logic [3:0]  strb;
            logic [6:0]  idx;
            bit          oor;
            idx  = 7'($urandom_range(0, 127));
            oor  = ($urandom_range(0, 5) == 0);
            addr = {23'h0, idx, 2'($urandom)};
            if (oor) addr = addr | (32'h1 << $urandom_range(9, 31));
            data = $urandom;
            strb = 4'($urandom);
            model_write(addr, data, strb);
            axi_write(addr, data, strb, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 2)), resp, pulses, pidx, ok);
            chk("rnd_done", ok, 1);
            chk("rnd_bresp", resp, oor ? 2'b10 : 2'b00);
            chk("rnd_pulses", pulses, (!oor && strb != 0) ? 1 : 0);
            if (!oor && strb != 0) chk("rnd_wr_idx", pidx, idx);
            rd_idx = idx;
            #1 chk("rnd_rd", rd_data, model[idx]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
